// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: valid/ready request to asynchronous-memory bus sequencer (setup/strobe/hold).
// Optional read-to-write turnaround cycle is compiled in with EXT_BUS_TURNAROUND_EN.
module ext_bus_ctrl #(
    parameter int AW = 19,
    parameter int DW = 8,
    parameter int NCH = 2,
    parameter int CHW = 1,
    parameter logic [4*NCH-1:0] WAITS = {4'd1, 4'd0}
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req,
    output logic           ready,
    input  logic           we,
    input  logic [CHW-1:0] ch,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  wdata,
    output logic [DW-1:0]  rdata,
    output logic           done,
    output logic [AW-1:0]  bus_addr,
    output logic [DW-1:0]  bus_dout,
    input  logic [DW-1:0]  bus_din,
    output logic           bus_oe,
    output logic [NCH-1:0] ce_n,
    output logic           we_n,
    output logic           oe_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3
`ifdef EXT_BUS_TURNAROUND_EN
        , TURN = 3'd4
`endif
    } state_t;

    // A channel number with no matching chip select still runs the sequence with zero waits.
    function automatic logic [3:0] wait_cycles(input logic [CHW-1:0] c);
        logic [3:0] w;
        w = 4'd0;
        for (int i = 0; i < NCH; i++) begin
            if (c == CHW'(i)) begin
                w = WAITS[4*i +: 4];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic logic [NCH-1:0] chip_sel(input logic [CHW-1:0] c);
        logic [NCH-1:0] cs;
        cs = {NCH{1'b1}};
        for (int i = 0; i < NCH; i++) begin
            if (c == CHW'(i)) begin
                cs[i] = 1'b0;
            end else begin
                cs[i] = 1'b1;
            end
        end
        return cs;
    endfunction

    function automatic logic ch_valid(input logic [CHW-1:0] c);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (c == CHW'(i)) begin
                v = 1'b1;
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    state_t         state_r, state_s;
    logic           we_r, we_s;
    logic [CHW-1:0] ch_r, ch_s;
    logic [3:0]     cnt_r, cnt_s;
    logic           accept_s, active_s, capture_s;
    logic           ready_s, done_s, bus_oe_s, we_n_s, oe_n_s;
    logic [NCH-1:0] ce_n_s;

    // Next state, captured request fields and next values of the registered bus outputs.
    always_comb begin
        accept_s = req && ready;
        state_s  = state_r;
        we_s     = we_r;
        ch_s     = ch_r;
        cnt_s    = cnt_r;
        if (accept_s) begin
            we_s  = we;
            ch_s  = ch;
            cnt_s = wait_cycles(ch);
        end else begin
            we_s  = we_r;
            ch_s  = ch_r;
            cnt_s = cnt_r;
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: state_s = STROBE;
            STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s = HOLD;
                end else begin
                    state_s = STROBE;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            HOLD: begin
                if (accept_s) begin
`ifdef EXT_BUS_TURNAROUND_EN
                    state_s = (!we_r && we) ? TURN : SETUP;
`else
                    state_s = SETUP;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef EXT_BUS_TURNAROUND_EN
            TURN: state_s = SETUP;
`endif
            default: state_s = IDLE;
        endcase

        // Outputs are decoded from the next state so every pin comes straight from a flop.
        active_s  = (state_s == SETUP) || (state_s == STROBE) || (state_s == HOLD);
        ready_s   = (state_s == IDLE) || (state_s == HOLD);
        done_s    = (state_s == HOLD);
        bus_oe_s  = active_s && we_s;
        ce_n_s    = active_s ? chip_sel(ch_s) : {NCH{1'b1}};
        we_n_s    = !((state_s == STROBE) && we_s);
        oe_n_s    = !((state_s == STROBE) && !we_s);
        capture_s = (state_r == STROBE) && (state_s == HOLD) && !we_r;
    end

    // Sequencer state, captured request and control/strobe output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            we_r    <= 1'b0;
            ch_r    <= {CHW{1'b0}};
            cnt_r   <= 4'd0;
            ready   <= 1'b1;
            done    <= 1'b0;
            bus_oe  <= 1'b0;
            ce_n    <= {NCH{1'b1}};
            we_n    <= 1'b1;
            oe_n    <= 1'b1;
        end else begin
            state_r <= state_s;
            we_r    <= we_s;
            ch_r    <= ch_s;
            cnt_r   <= cnt_s;
            ready   <= ready_s;
            done    <= done_s;
            bus_oe  <= bus_oe_s;
            ce_n    <= ce_n_s;
            we_n    <= we_n_s;
            oe_n    <= oe_n_s;
        end
    end

    // Address and write data change only on accept and otherwise keep their last values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_addr <= {AW{1'b0}};
            bus_dout <= {DW{1'b0}};
        end else if (accept_s) begin
            bus_addr <= addr;
            bus_dout <= we ? wdata : bus_dout;
        end else begin
            bus_addr <= bus_addr;
            bus_dout <= bus_dout;
        end
    end

    // Read data sampled on the edge leaving STROBE; unmapped channels read as all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= {DW{1'b0}};
        end else if (capture_s) begin
            rdata <= ch_valid(ch_r) ? bus_din : {DW{1'b1}};
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomized bench for ext_bus_ctrl: a per-cycle timeline of expected pin values is built from
// each accepted transfer (setup/strobe/hold spans) and compared every cycle.
module tb_ext_bus_ctrl;
    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int NCH  = 2;
    localparam int CHW  = 2;
    localparam int NCYC = 2048;
`ifdef EXT_BUS_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           req = 1'b0;
    logic           we = 1'b0;
    logic [CHW-1:0] ch = 2'd0;
    logic [AW-1:0]  addr = 19'd0;
    logic [DW-1:0]  wdata = 8'd0;
    logic [DW-1:0]  bus_din;
    logic           ready, done, bus_oe, we_n, oe_n;
    logic [DW-1:0]  rdata, bus_dout;
    logic [AW-1:0]  bus_addr;
    logic [NCH-1:0] ce_n;

    ext_bus_ctrl #(.AW(AW), .DW(DW), .NCH(NCH), .CHW(CHW), .WAITS({4'd1, 4'd0})) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ready(ready), .we(we), .ch(ch),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_oe(bus_oe), .ce_n(ce_n),
        .we_n(we_n), .oe_n(oe_n)
    );

    always #5 clk = ~clk;

    // Device model: data appears only while the read strobe is low.
    function automatic logic [DW-1:0] dev_data(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction
    assign bus_din = oe_n ? 8'hEE : dev_data(bus_addr);

    typedef struct {
        logic [NCH-1:0] ce_n;
        logic we_n, oe_n, oe, done, busy, addr_v, dout_v, rd_v;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout, rd;
    } exp_t;
    typedef struct {
        int gap;
        logic wr;
        int chn;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    exp_t sched [NCYC];
    txn_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_hold = -1;
    logic last_we = 1'b0;
    int   waits_tab[4] = '{0, 1, 0, 0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Lay out the expected timeline of a transfer accepted on clock edge a.
    task automatic schedule(input int a, input txn_t t);
        int w, s, h;
        logic [NCH-1:0] cs;
        w  = waits_tab[t.chn];
        s  = a + ((TURN_EN && last_hold == a - 1 && !last_we && t.wr) ? 1 : 0);
        h  = s + 2 + w;
        cs = {NCH{1'b1}};
        if (t.chn < NCH) cs[t.chn] = 1'b0;
        sched[a].addr_v = 1'b1;
        sched[a].addr   = t.a;
        if (t.wr) begin
            sched[a].dout_v = 1'b1;
            sched[a].dout   = t.d;
        end
        for (int i = a; i < h; i++) sched[i].busy = 1'b1;
        for (int i = s; i <= h; i++) begin
            sched[i].ce_n = cs;
            sched[i].oe   = t.wr;
        end
        for (int i = s + 1; i <= s + 1 + w; i++) begin
            if (t.wr) sched[i].we_n = 1'b0;
            else      sched[i].oe_n = 1'b0;
        end
        sched[h].done = 1'b1;
        if (!t.wr) begin
            sched[h].rd_v = 1'b1;
            sched[h].rd   = (t.chn < NCH) ? dev_data(t.a) : 8'hFF;
        end
        last_hold = h;
        last_we   = t.wr;
    endtask

    task automatic add_txn(input int gap, input logic wr, input int chn,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.gap = gap; t.wr = wr; t.chn = chn; t.a = a; t.d = d;
        q.push_back(t);
    endtask

    initial begin
        txn_t          cur;
        logic          pres;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_dout, cur_rd;

        for (int i = 0; i < NCYC; i++) begin
            sched[i].ce_n = {NCH{1'b1}};
            sched[i].we_n = 1'b1;  sched[i].oe_n = 1'b1;  sched[i].oe = 1'b0;
            sched[i].done = 1'b0;  sched[i].busy = 1'b0;  sched[i].addr_v = 1'b0;
            sched[i].dout_v = 1'b0; sched[i].rd_v = 1'b0;
            sched[i].addr = 19'd0; sched[i].dout = 8'd0; sched[i].rd = 8'd0;
        end
        add_txn(2, 1'b1, 0, 19'h00123, 8'hA5);
        add_txn(5, 1'b0, 1, 19'h00000, 8'h00);
        add_txn(5, 1'b1, 0, 19'h00010, 8'h11);
        add_txn(0, 1'b1, 0, 19'h00011, 8'h22);
        add_txn(0, 1'b1, 0, 19'h00012, 8'h33);
        add_txn(5, 1'b0, 0, 19'h01234, 8'h00);
        add_txn(0, 1'b1, 1, 19'h04321, 8'h77);
        add_txn(5, 1'b0, 2, 19'h00055, 8'h00);
        for (int i = 0; i < 220; i++) begin
            add_txn(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    AW'($urandom()), DW'($urandom()));
        end

        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rdata", rdata, 8'h00);
        check_eq("rst_bus_addr", bus_addr, 19'd0);
        check_eq("rst_bus_dout", bus_dout, 8'h00);
        check_eq("rst_bus_oe", bus_oe, 1'b0);
        check_eq("rst_ce_n", ce_n, 2'b11);
        check_eq("rst_we_n", we_n, 1'b1);
        check_eq("rst_oe_n", oe_n, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        pres = 1'b0;
        cur_addr = 19'd0; cur_dout = 8'd0; cur_rd = 8'd0;
        for (int k = 0; k < NCYC; k++) begin
            if (!pres && q.size() > 0 && k < NCYC - 48) begin
                cur = q[0];
                if (cur.gap == 0) begin
                    pres = 1'b1;
                    q.delete(0);
                end else begin
                    cur.gap = cur.gap - 1;
                    q[0] = cur;
                end
            end
            if (pres) begin
                req = 1'b1; we = cur.wr; ch = CHW'(cur.chn); addr = cur.a; wdata = cur.d;
            end else begin
                req = 1'b0; we = 1'($urandom_range(0, 1)); ch = CHW'($urandom_range(0, 3));
                addr = AW'($urandom()); wdata = DW'($urandom());
            end
            @(posedge clk);
            if (pres && k - 1 >= last_hold) begin
                schedule(k, cur);
                pres = 1'b0;
            end
            @(negedge clk);
            if (sched[k].addr_v) cur_addr = sched[k].addr;
            if (sched[k].dout_v) cur_dout = sched[k].dout;
            if (sched[k].rd_v)   cur_rd   = sched[k].rd;
            check_eq("ce_n", ce_n, sched[k].ce_n);
            check_eq("we_n", we_n, sched[k].we_n);
            check_eq("oe_n", oe_n, sched[k].oe_n);
            check_eq("bus_oe", bus_oe, sched[k].oe);
            check_eq("done", done, sched[k].done);
            check_eq("ready", ready, !sched[k].busy);
            check_eq("bus_addr", bus_addr, cur_addr);
            check_eq("bus_dout", bus_dout, cur_dout);
            check_eq("rdata", rdata, cur_rd);
        end
        check_eq("queue_drained", q.size(), 0);

        // Reset asserted in the middle of a write strobe on channel 1.
        req = 1'b1; we = 1'b1; ch = 2'd1; addr = 19'h2AAAA; wdata = 8'h5A;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2;
        check_eq("mid_we_n", we_n, 1'b0);
        check_eq("mid_ce_n", ce_n, 2'b01);
        check_eq("mid_bus_oe", bus_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_we_n", we_n, 1'b1);
        check_eq("arst_ce_n", ce_n, 2'b11);
        check_eq("arst_bus_oe", bus_oe, 1'b0);
        check_eq("arst_done", done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("arst_no_done", done, 1'b0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", ready, 1'b1);
        check_eq("post_rst_rdata", rdata, 8'h00);
        check_eq("post_rst_ce_n", ce_n, 2'b11);
        check_eq("post_rst_done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
